// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with optional 2-entry skid buffer
//
// Purpose: carries a data and a control payload across one datapath stage
// boundary. It supports synchronous flush (bubble insertion), back-pressure
// and a saturating stall-cycle counter.
//
// Build option: PIPE_STAGE_SKID_EN
//   defined   - adds a skid register and a FULL state; in_ready is registered
//   undefined - main register only; in_ready = out_ready | !out_valid (combinational)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush_i              synchronous flush; kills every held entry and drops the current offer
//   in_valid/in_ready    upstream handshake
//   in_data/in_ctrl      upstream payload
//   out_valid/out_ready  downstream handshake
//   out_data/out_ctrl    main-register payload; out_ctrl is 0 whenever out_valid is 0
//   stall_cnt            saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Stall counter: independent of flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  in_ready_q;
  logic                  in_xfer;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;

  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      // Registered ready: only FULL refuses input, so ready never waits on out_ready.
      in_ready_q <= (next_state != FULL);
    end
  end

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            next_state   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid  = 1'b1;
            next_state = FULL;
          end else if (out_ready) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            next_state     = ONE;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        out_data <= skid_data;
        out_ctrl <= skid_ctrl;
      end else if (next_state == EMPTY) begin
        // Bubble: control goes to 0, data keeps its last value.
        out_ctrl <= '0;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end else if (flush_i || load_main_skid) begin
        skid_ctrl <= '0;
      end
    end
  end

`else

  typedef enum logic {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_t;

  state_t state;
  state_t next_state;
  logic   in_xfer;
  logic   load_main;

  assign out_valid = (state == ONE);
  // Without a skid slot the stage may only accept when the held entry leaves now.
  assign in_ready  = out_ready | ~out_valid;
  assign in_xfer   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    if (flush_i) begin
      next_state = EMPTY;
    end else if (in_xfer) begin
      load_main  = 1'b1;
      next_state = ONE;
    end else if (out_ready) begin
      next_state = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ctrl <= '0;
    end else if (load_main) begin
      out_data <= in_data;
      out_ctrl <= in_ctrl;
    end else if (next_state == EMPTY) begin
      out_ctrl <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          flush_i   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [CW-1:0] in_ctrl   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [CW+DW-1:0] sb[$];
  logic [NW-1:0]    exp_stall = '0;
  logic [DW-1:0]    pend[$];
  logic             acc;

  pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples mid-cycle, compares the DUT against the model,
  // then applies this cycle's handshakes to the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_stall = '0;
    end else begin
      check("valid_vs_model", 72'(out_valid), 72'(sb.size() != 0));
      if (!out_valid) check("bubble_ctrl", 72'(out_ctrl), 72'(0));
      if (sb.size() != 0) begin
        check("head_data", 72'(out_data), 72'(sb[0][DW-1:0]));
        check("head_ctrl", 72'(out_ctrl), 72'(sb[0][CW+DW-1:DW]));
      end
`ifdef PIPE_STAGE_SKID_EN
      check("in_ready_model", 72'(in_ready), 72'(sb.size() < CAP));
`else
      check("in_ready_model", 72'(in_ready), 72'(out_ready || (sb.size() == 0)));
`endif
      check("stall_model", 72'(stall_cnt), 72'(exp_stall));
      if ((sb.size() != 0) && !out_ready && (exp_stall != 4'hF)) exp_stall = exp_stall + 4'd1;
      if ((sb.size() != 0) && out_ready) void'(sb.pop_front());
      if (flush_i) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_in_ready",  72'(in_ready),  72'(1));
    check("rst_out_data",  72'(out_data),  72'(0));
    check("rst_out_ctrl",  72'(out_ctrl),  72'(0));
    check("rst_stall",     72'(stall_cnt), 72'(0));
    rst_n = 1'b1;
    cyc();

    // Streaming 0x1..0x8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      in_ctrl  = 8'hFF;
      check("stream_in_ready", 72'(in_ready), 72'(1));
      cyc();
      check("stream_valid", 72'(out_valid), 72'(1));
      check("stream_data",  72'(out_data),  72'(i));
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drain", 72'(out_valid), 72'(0));

    // Back-pressure: A, B, C with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h10;
    in_ctrl   = 8'h01;
    cyc();
    in_data = 64'h20;
    in_ctrl = 8'h02;
    cyc();
`ifdef PIPE_STAGE_SKID_EN
    in_data = 64'h30;
    in_ctrl = 8'h03;
    pend = {64'h30};
`else
    pend = {64'h20, 64'h30};
`endif
    cyc();
    cyc();
    check("bp_in_ready", 72'(in_ready),  72'(0));
    check("bp_data",     72'(out_data),  72'(64'h10));
    check("bp_stall",    72'(stall_cnt), 72'(3));
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 20 && pend.size() != 0; k++) begin
      acc = in_valid & in_ready;
      cyc();
      if (acc) begin
        void'(pend.pop_front());
        if (pend.size() != 0) begin
          in_data = pend[0];
          in_ctrl = pend[0][11:4];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("bp_pending_left", 72'(pend.size()), 72'(0));
    in_valid = 1'b0;
    repeat (3) cyc();
    check("bp_drained", 72'(out_valid), 72'(0));

    // out_ready toggling under a continuous offer
    in_valid = 1'b1;
    in_data  = 64'h40;
    in_ctrl  = 8'h04;
    for (int k = 0; k < 12; k++) begin
      out_ready = k[0];
      #1;
      acc = in_valid & in_ready;
      cyc();
      if (acc) begin
        in_data = in_data + 64'h1;
        in_ctrl = in_ctrl + 8'h1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    check("toggle_drained", 72'(out_valid), 72'(0));

    // Flush with the stage loaded and a new offer in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    in_ctrl   = 8'h81;
    cyc();
    in_data = 64'h22;
    in_ctrl = 8'h42;
    cyc();
    flush_i = 1'b1;
    in_data = 64'h99;
    in_ctrl = 8'h77;
    cyc();
    flush_i  = 1'b0;
    in_valid = 1'b0;
    check("flush_valid",    72'(out_valid), 72'(0));
    check("flush_ctrl",     72'(out_ctrl),  72'(0));
    check("flush_in_ready", 72'(in_ready),  72'(1));
    check("flush_data",     72'(out_data),  72'(64'h11));
    out_ready = 1'b1;
    repeat (3) begin
      cyc();
      check("flush_no_leak", 72'(out_valid), 72'(0));
    end

    // Stall counter saturation at 15
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 8'h0F;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("sat_stall", 72'(stall_cnt), 72'(15));
    check("sat_data",  72'(out_data),  72'(64'h55));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("stall_after_flush", 72'(stall_cnt), 72'(15));

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    in_data  = 64'h66;
    in_ctrl  = 8'h3C;
    cyc();
    in_data = 64'h77;
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 72'(out_valid), 72'(0));
    check("arst_out_ctrl",  72'(out_ctrl),  72'(0));
    check("arst_out_data",  72'(out_data),  72'(0));
    check("arst_in_ready",  72'(in_ready),  72'(1));
    check("arst_stall",     72'(stall_cnt), 72'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_valid", 72'(out_valid), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
